// File: rtl/hs4_pipe_pkg.sv
// Shared types and constants for the four-phase handshake pipeline sequencer.
package hs4_pipe_pkg;

   typedef enum logic {IN_IDLE, IN_ACK} in_state_t;

   typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_RTZ} out_state_t;

   // Stage data registers reset to all copies of this bit.
   localparam logic DATA_RST_BIT = 1'b0;

endpackage

// File: rtl/hs4_pipe_ctrl_sync.sv
// hs_sync: STAGES-flop synchronizer, async active-low reset to 0; a plain wire when STAGES=0.
module hs_sync #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rstn,
   input  logic d_i,
   output logic q_o
);

   generate
      if (STAGES == 0) begin : g_bypass
         logic clk_rst_unused;
         assign clk_rst_unused = i_clk & i_rstn;
         assign q_o = d_i;
      end else begin : g_flops
         logic [STAGES-1:0] sync_q;
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= d_i;
               for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
            end
         end
         assign q_o = sync_q[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/hs4_pipe_ctrl.sv
// DEPTH-stage micropipeline emulator: four-phase handshake in, bubble-rule stage advance,
// four-phase handshake out.
module hs4_pipe_ctrl
   import hs4_pipe_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rstn,
   input  logic                       i_req,
   input  logic [WIDTH-1:0]           i_data,
   output logic                       o_ack,
   output logic                       o_req,
   output logic [WIDTH-1:0]           o_data,
   input  logic                       i_ack,
   output logic [DEPTH-1:0]           o_stage_en,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int CW = $clog2(DEPTH + 1);

   logic req_s, ack_s;

   hs_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
      .i_clk (i_clk), .i_rstn (i_rstn), .d_i (i_req), .q_o (req_s)
   );

   hs_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .i_clk (i_clk), .i_rstn (i_rstn), .d_i (i_ack), .q_o (ack_s)
   );

   in_state_t                     in_q, in_d;
   out_state_t                    out_q, out_d;
   logic                          ack_q, ack_d, req_q, req_d;
   logic                          load0, deliver;
   logic [DEPTH-1:0]              valid, valid_d, en;
   logic [DEPTH-1:0][WIDTH-1:0]   data_vec;
   logic [CW-1:0]                 count_q, count_d;

   // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      in_d  = in_q;
      ack_d = ack_q;
      load0 = 1'b0;
      case (in_q)
         IN_IDLE: if (req_s && !valid[0]) begin
            load0 = 1'b1;
            ack_d = 1'b1;
            in_d  = IN_ACK;
         end
         IN_ACK: if (!req_s) begin
            ack_d = 1'b0;
            in_d  = IN_IDLE;
         end
         default: begin
            ack_d = 1'b0;
            in_d  = IN_IDLE;
         end
      endcase
   end

   always_comb begin
      out_d   = out_q;
      req_d   = req_q;
      deliver = 1'b0;
      case (out_q)
         OUT_IDLE: if (valid[DEPTH-1]) begin
            req_d = 1'b1;
            out_d = OUT_REQ;
         end
         OUT_REQ: if (ack_s) begin
            req_d   = 1'b0;
            deliver = 1'b1;
            out_d   = OUT_RTZ;
         end
         OUT_RTZ: if (!ack_s) out_d = OUT_IDLE;
         default: begin
            req_d = 1'b0;
            out_d = OUT_IDLE;
         end
      endcase
   end

   // Bubble rule on pre-edge state: a stage only fills when it is already empty.
   always_comb begin
      en    = '0;
      en[0] = load0;
      for (int i = 0; i < DEPTH - 1; i++) en[i+1] = valid[i] & ~valid[i+1];
   end

   always_comb begin
      valid_d = valid;
      for (int i = 1; i < DEPTH; i++) begin
         if (en[i]) begin
            valid_d[i]   = 1'b1;
            valid_d[i-1] = 1'b0;
         end
      end
      if (load0)   valid_d[0]       = 1'b1;
      if (deliver) valid_d[DEPTH-1] = 1'b0;
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) count_d = count_d + CW'(valid_d[i]);
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         in_q    <= IN_IDLE;
         out_q   <= OUT_IDLE;
         ack_q   <= 1'b0;
         req_q   <= 1'b0;
         count_q <= '0;
      end else begin
         in_q    <= in_d;
         out_q   <= out_d;
         ack_q   <= ack_d;
         req_q   <= req_d;
         count_q <= count_d;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      logic [WIDTH-1:0] src;
      logic [WIDTH-1:0] data_q;
      logic             valid_q;

      if (g == 0) begin : g_head
         assign src = i_data;
      end else begin : g_link
         assign src = data_vec[g-1];
      end

      // NOTE: data registers are reset too, so o_data is defined (zero) straight out of reset.
      always_ff @(posedge i_clk or negedge i_rstn) begin
         if (!i_rstn) begin
            data_q  <= {WIDTH{DATA_RST_BIT}};
            valid_q <= 1'b0;
         end else begin
            valid_q <= valid_d[g];
            if (en[g]) data_q <= src;
         end
      end

      assign data_vec[g] = data_q;
      assign valid[g]    = valid_q;
   end

   assign o_ack      = ack_q;
   assign o_req      = req_q;
   assign o_data     = data_vec[DEPTH-1];
   assign o_stage_en = en;
   assign o_count    = count_q;

endmodule
